uart_rx: RTL and testbench

- UART receiver, the receive-side counterpart of the system's UART transmitter. Same frame format: 1 start bit (0), WIDTH data bits LSB first, optional parity bit, 1 stop bit (1).
- Runs on an oversampled clock, PRESCALE clock cycles per bit. Each bit is recovered by majority vote over three mid-bit samples.
- Presents the received word on a parallel bus with a single-cycle valid pulse, plus parity and stop error flags, to the system control block.

---
 rtl/uart_rx.sv | 138 +++++++++++++
 tb/tb_uart_rx.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: start bit, WIDTH data bits LSB first, optional parity bit,
// one stop bit. Each bit lasts PRESCALE clock cycles and is recovered by a
// majority vote of three samples around the middle of the bit.
//
// Output handshake: DATA_VALID is a one-cycle pulse with no ready/back-pressure;
// P_DATA is stable from that pulse until the next accepted frame, and
// PAR_ERR/STP_ERR describe the most recently completed frame.
module uart_rx #(
   parameter int WIDTH = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             RX_IN,
   input  logic [5:0]       PRESCALE,
   input  logic             PAR_EN,
   input  logic             PAR_TYP,
   output logic [WIDTH-1:0] P_DATA,
   output logic             DATA_VALID,
   output logic             PAR_ERR,
   output logic             STP_ERR,
   output logic [2:0]       state_dbg
);

   localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      DONE   = 3'd5
   } state_t;

   state_t           state;
   logic [5:0]       edge_cnt;
   logic [BW-1:0]    bit_cnt;
   logic [WIDTH-1:0] shift_reg;
   logic             s0, s1, s2;
   logic             par_en_q, par_typ_q;
   logic             par_err_int;

   logic [5:0] half;
   logic       last_edge;
   logic       vote;

   assign half      = {1'b0, PRESCALE[5:1]};
   assign last_edge = (edge_cnt == PRESCALE - 6'd1);
   assign vote      = (s0 & s1) | (s0 & s2) | (s1 & s2);
   assign state_dbg = state;

   // Frame FSM, bit timing, mid-bit sampling and registered outputs.
   // The DONE-cycle actions are registered on the STOP->DONE edge so that
   // outputs are visible during the DONE cycle itself.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state       <= IDLE;
         edge_cnt    <= '0;
         bit_cnt     <= '0;
         shift_reg   <= '0;
         s0          <= 1'b0;
         s1          <= 1'b0;
         s2          <= 1'b0;
         par_en_q    <= 1'b0;
         par_typ_q   <= 1'b0;
         par_err_int <= 1'b0;
         P_DATA      <= '0;
         DATA_VALID  <= 1'b0;
         PAR_ERR     <= 1'b0;
         STP_ERR     <= 1'b0;
      end else begin
         DATA_VALID <= 1'b0;

         if (state != IDLE && state != DONE) begin
            edge_cnt <= last_edge ? 6'd0 : edge_cnt + 6'd1;
            if (edge_cnt == half - 6'd1) s0 <= RX_IN;
            if (edge_cnt == half)        s1 <= RX_IN;
            if (edge_cnt == half + 6'd1) s2 <= RX_IN;
         end

         case (state)
            IDLE, DONE: begin
               // A low line here is edge 0 of a start bit, so the counter
               // resumes at 1; this also covers back-to-back frames from DONE.
               if (!RX_IN) begin
                  state       <= START;
                  edge_cnt    <= 6'd1;
                  par_en_q    <= PAR_EN;
                  par_typ_q   <= PAR_TYP;
                  par_err_int <= 1'b0;
               end else begin
                  state    <= IDLE;
                  edge_cnt <= 6'd0;
               end
            end
            START: begin
               if (last_edge) begin
                  bit_cnt <= '0;
                  state   <= vote ? IDLE : DATA;
               end
            end
            DATA: begin
               if (last_edge) begin
                  shift_reg <= {vote, shift_reg[WIDTH-1:1]};
                  if (bit_cnt == BW'(WIDTH - 1)) begin
                     bit_cnt <= '0;
                     state   <= par_en_q ? PARITY : STOP;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end
            PARITY: begin
               if (last_edge) begin
                  par_err_int <= vote != (^shift_reg ^ par_typ_q);
                  state       <= STOP;
               end
            end
            STOP: begin
               if (last_edge) begin
                  state   <= DONE;
                  PAR_ERR <= par_en_q & par_err_int;
                  STP_ERR <= ~vote;
                  if (vote && !(par_en_q && par_err_int)) begin
                     P_DATA     <= shift_reg;
                     DATA_VALID <= 1'b1;
                  end
               end
            end
            default: begin
               state    <= IDLE;
               edge_cnt <= 6'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frames from the test plan followed by random
// frames, compared against a frame-level model of what the receiver accepts.
module tb_uart_rx;

   logic       CLK;
   logic       RST;
   logic       RX_IN;
   logic [5:0] PRESCALE;
   logic       PAR_EN;
   logic       PAR_TYP;
   logic [7:0] P_DATA;
   logic       DATA_VALID;
   logic       PAR_ERR;
   logic       STP_ERR;
   logic [2:0] state_dbg;

   uart_rx #(.WIDTH(8)) dut (
      .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PRESCALE(PRESCALE),
      .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .P_DATA(P_DATA),
      .DATA_VALID(DATA_VALID), .PAR_ERR(PAR_ERR), .STP_ERR(STP_ERR),
      .state_dbg(state_dbg)
   );

   // clock / reset
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc++;

   // scoreboard
   int total = 0;
   int bad   = 0;
   logic [7:0]  exp_q[$];
   logic [31:0] exp_cyc_q[$];

   // model of the last completed frame
   logic [7:0] m_data = 8'h00;
   logic       m_par  = 1'b0;
   logic       m_stp  = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // monitor: every valid pulse must match the next expected word and cycle
   logic prev_valid = 1'b0;
   always @(negedge CLK) begin
      if (RST) begin
         if (DATA_VALID) begin
            if (prev_valid) check_eq("valid_twice", 32'd1, 32'd0);
            if (exp_q.size() == 0) begin
               check_eq("spurious_valid", {24'd0, P_DATA}, 32'hFFFF_FFFF);
            end else begin
               check_eq("p_data", {24'd0, P_DATA}, {24'd0, exp_q.pop_front()});
               check_eq("valid_cycle", cyc, exp_cyc_q.pop_front());
            end
         end
      end
      prev_valid = DATA_VALID;
   end

   // drivers: all called just after a rising edge
   task automatic drive_bit(input logic b, input int n);
      RX_IN = b;
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic idle(input int n);
      drive_bit(1'b1, n);
   endtask

   // Sends one frame. glitch >= 0 flips the line for one cycle at the middle
   // of that data bit. Ends at the first cycle after the stop bit.
   task automatic send_frame(input logic [7:0] d, input int p, input logic pe,
                             input logic pt, input logic par_flip,
                             input logic stop_b, input int glitch);
      int         start;
      int         nbits;
      logic       par_bit;
      logic       exp_par, exp_stp, ok;
      PRESCALE = 6'(p);
      PAR_EN   = pe;
      PAR_TYP  = pt;
      start    = cyc;
      par_bit  = (^d) ^ pt ^ par_flip;
      nbits    = 1 + 8 + (pe ? 1 : 0) + 1;
      exp_par  = pe & par_flip;
      exp_stp  = ~stop_b;
      ok       = !exp_par && !exp_stp;
      if (ok) begin
         exp_q.push_back(d);
         exp_cyc_q.push_back(32'(start + nbits * p));
      end
      drive_bit(1'b0, p);
      for (int i = 0; i < 8; i++) begin
         if (i == glitch) begin
            drive_bit(d[i], p / 2);
            drive_bit(~d[i], 1);
            drive_bit(d[i], p - p / 2 - 1);
         end else begin
            drive_bit(d[i], p);
         end
      end
      if (pe) drive_bit(par_bit, p);
      drive_bit(stop_b, p);
      // now in the DONE cycle
      if (ok) m_data = d;
      m_par = exp_par;
      m_stp = exp_stp;
      check_eq("done_cycle", cyc, 32'(start + nbits * p));
      check_eq("valid_now", {31'd0, DATA_VALID}, {31'd0, ok});
      check_eq("par_err", {31'd0, PAR_ERR}, {31'd0, m_par});
      check_eq("stp_err", {31'd0, STP_ERR}, {31'd0, m_stp});
      check_eq("p_data_hold", {24'd0, P_DATA}, {24'd0, m_data});
   endtask

   task automatic check_outputs(input string tag);
      check_eq({tag, "_data"}, {24'd0, P_DATA}, {24'd0, m_data});
      check_eq({tag, "_par"},  {31'd0, PAR_ERR}, {31'd0, m_par});
      check_eq({tag, "_stp"},  {31'd0, STP_ERR}, {31'd0, m_stp});
      check_eq({tag, "_valid"}, {31'd0, DATA_VALID}, 32'd0);
   endtask

   initial begin
      int   p, gap, g;
      logic pe, pt, pf, sb;
      logic [7:0] d;
      int   p_tab[3];
      p_tab[0] = 8; p_tab[1] = 16; p_tab[2] = 32;

      RST = 1'b0; RX_IN = 1'b1; PRESCALE = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      check_outputs("reset");
      RST = 1'b1;
      idle(4);

      // clean frame with even parity
      send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b0, 1'b1, -1);
      idle(5);
      // no parity at 16 and 32
      send_frame(8'h3C, 16, 1'b0, 1'b0, 1'b0, 1'b1, -1);
      idle(5);
      send_frame(8'hFF, 32, 1'b0, 1'b0, 1'b0, 1'b1, -1);
      idle(5);
      // odd parity: wrong then correct
      send_frame(8'h01, 8, 1'b1, 1'b1, 1'b1, 1'b1, -1);
      idle(5);
      send_frame(8'h01, 8, 1'b1, 1'b1, 1'b0, 1'b1, -1);
      idle(5);
      // stop bit low
      send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b0, -1);
      idle(5);
      // start glitch: flags and data untouched
      PRESCALE = 6'd8;
      drive_bit(1'b0, 3);
      idle(20);
      check_outputs("start_glitch");
      // one-cycle glitch at a data bit's mid sample
      send_frame(8'h6B, 8, 1'b0, 1'b0, 1'b0, 1'b1, 3);
      idle(5);
      // back-to-back
      send_frame(8'h12, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1);
      send_frame(8'h34, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1);
      idle(5);
      // reset mid-frame
      drive_bit(1'b0, 8);
      drive_bit(1'b1, 12);
      RST = 1'b0;
      #1;
      m_data = 8'h00; m_par = 1'b0; m_stp = 1'b0;
      check_outputs("mid_reset");
      RX_IN = 1'b1;
      @(posedge CLK);
      #1;
      RST = 1'b1;
      idle(120);
      check_outputs("after_reset");

      // random frames
      p = 8;
      for (int i = 0; i < 30; i++) begin
         d  = 8'($urandom_range(0, 255));
         pe = 1'($urandom_range(0, 1));
         pt = 1'($urandom_range(0, 1));
         pf = ($urandom_range(0, 3) == 0);
         sb = ($urandom_range(0, 5) != 0);
         g  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : -1;
         send_frame(d, p, pe, pt, pf, sb, g);
         gap = $urandom_range(0, 3);
         if (!sb && gap == 0) gap = 1;
         if (gap > 0) begin
            idle(gap);
            p = p_tab[$urandom_range(0, 2)];
         end
      end
      idle(10);
      check_eq("exp_q_empty", exp_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
